// File: rtl/ddco_adder_pkg.sv
// Shared definitions for the sequential chunked adder.
// Contents: FSM state encoding and default operand/chunk widths.
package ddco_adder_pkg;

  localparam int unsigned DEF_WIDTH = 16;
  localparam int unsigned DEF_CHUNK = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_ripple_adder_if.sv
// Request/result bundle for seq_ripple_adder.
// master: drives start, sub, a, b, cin; observes sum, cout, ovf, busy, done.
// slave : the adder side of the same signals.
interface seq_ripple_adder_if
  import ddco_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
);

  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             busy;
  logic             done;

  modport master (
    output start, sub, a, b, cin,
    input  sum, cout, ovf, busy, done
  );

  modport slave (
    input  start, sub, a, b, cin,
    output sum, cout, ovf, busy, done
  );

endinterface

// File: rtl/chunk_ripple_adder.sv
// Combinational CHUNK-bit ripple-carry adder built from full adders.
// Ports: a, b (CHUNK bits), cin -> sum (CHUNK bits), cout.
module chunk_ripple_adder
  import ddco_adder_pkg::*;
#(
  parameter int unsigned CHUNK = DEF_CHUNK
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout
);

  logic [CHUNK:0] c;

  assign c[0] = cin;

  // One full adder per bit; carry ripples from bit 0 upward.
  for (genvar i = 0; i < int'(CHUNK); i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[CHUNK];

endmodule

// File: rtl/seq_ripple_adder.sv
// Multi-cycle WIDTH-bit adder/subtractor processing CHUNK bits per clock.
// Ports: clk, rst_n (async active-low), bus (slave modport):
//   start/sub/a/b/cin request an operation in IDLE; sum/cout/ovf are the
//   registered result, busy marks RUN, done pulses for one cycle in DONE.
module seq_ripple_adder
  import ddco_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CHUNK = DEF_CHUNK
) (
  input  logic                 clk,
  input  logic                 rst_n,
  seq_ripple_adder_if.slave    bus
);

  localparam int unsigned NCH  = WIDTH / CHUNK;
  localparam int unsigned IDXW = (NCH > 1) ? $clog2(NCH) : 1;

  state_t            state;
  state_t            state_nx;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic              carry;
  logic [IDXW-1:0]   idx;
  logic [CHUNK-1:0]  ch_a;
  logic [CHUNK-1:0]  ch_b;
  logic [CHUNK-1:0]  ch_sum;
  logic              ch_cout;
  logic              last_c;

  // Select the operand slices for the current chunk.
  always_comb begin
    ch_a = '0;
    ch_b = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (idx == IDXW'(i)) begin
        ch_a = a_q[i*CHUNK +: CHUNK];
        ch_b = b_q[i*CHUNK +: CHUNK];
      end
    end
  end

  assign last_c = (idx == IDXW'(NCH - 1));

  chunk_ripple_adder #(
    .CHUNK (CHUNK)
  ) u_chunk (
    .a    (ch_a),
    .b    (ch_b),
    .cin  (carry),
    .sum  (ch_sum),
    .cout (ch_cout)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: if (bus.start) state_nx = ST_RUN;
      ST_RUN:  if (last_c)    state_nx = ST_DONE;
      ST_DONE:                state_nx = ST_IDLE;
      default:                state_nx = ST_IDLE;
    endcase
  end

  // Operand latch, chunk accumulation and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      carry    <= 1'b0;
      idx      <= '0;
      bus.sum  <= '0;
      bus.cout <= 1'b0;
      bus.ovf  <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      bus.busy <= (state_nx == ST_RUN);
      bus.done <= (state_nx == ST_DONE);
      unique case (state)
        ST_IDLE: begin
          if (bus.start) begin
            // Subtraction is a + ~b + 1; cin only matters for addition.
            a_q     <= bus.a;
            b_q     <= bus.sub ? ~bus.b : bus.b;
            carry   <= bus.sub ? 1'b1 : bus.cin;
            idx     <= '0;
            bus.sum <= '0;
          end
        end
        ST_RUN: begin
          for (int unsigned i = 0; i < NCH; i++) begin
            if (idx == IDXW'(i)) bus.sum[i*CHUNK +: CHUNK] <= ch_sum;
          end
          carry <= ch_cout;
          idx   <= idx + IDXW'(1);
          if (last_c) begin
            // ch_sum's top bit is the result MSB on the final chunk.
            bus.cout <= ch_cout;
            bus.ovf  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                        (ch_sum[CHUNK-1] != a_q[WIDTH-1]);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_ripple_adder.sv
// Self-checking bench for seq_ripple_adder: a 4-bit-chunk and a single-chunk
// build run side by side against an arithmetic reference model.
module tb_seq_ripple_adder;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  seq_ripple_adder_if #(.WIDTH(16)) if4  ();
  seq_ripple_adder_if #(.WIDTH(16)) if16 ();

  seq_ripple_adder #(.WIDTH(16), .CHUNK(4)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if4)
  );

  seq_ripple_adder #(.WIDTH(16), .CHUNK(16)) u_dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference result: {ovf, cout, sum} from plain integer arithmetic.
  function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic sub, input logic cin);
    logic [31:0] t;
    int          sa;
    int          sb;
    int          st;
    logic        c;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (!sub) begin
      t  = 32'(a) + 32'(b) + 32'(cin);
      c  = t[16];
      st = sa + sb + int'(cin);
    end else begin
      t  = 32'(a) - 32'(b);
      c  = (a >= b);
      st = sa - sb;
    end
    return {(st > 32767 || st < -32768), c, t[15:0]};
  endfunction

  // Per-cycle expectation for one DUT, k = edges after the start edge.
  task automatic chk_cycle(input string tag, input int nch, input int k,
                           input logic busy, input logic done,
                           input logic [15:0] sum, input logic cout, input logic ovf,
                           input logic [17:0] exp);
    check($sformatf("%s busy k%0d", tag, k), 32'(busy), 32'(k < nch));
    check($sformatf("%s done k%0d", tag, k), 32'(done), 32'(k == nch));
    if (k == 0 && nch > 1) check($sformatf("%s sum clr", tag), 32'(sum), 32'h0);
    if (k == nch || k == 6) begin
      check($sformatf("%s sum k%0d", tag, k),  32'(sum),  32'(exp[15:0]));
      check($sformatf("%s cout k%0d", tag, k), 32'(cout), 32'(exp[16]));
      check($sformatf("%s ovf k%0d", tag, k),  32'(ovf),  32'(exp[17]));
    end
  endtask

  // One operation on both DUTs; hold keeps start high on the 4-chunk DUT
  // through RUN and DONE to show it is ignored there.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic sub, input logic cin, input bit hold);
    logic [17:0] exp;
    exp = model(a, b, sub, cin);
    @(negedge clk);
    if4.a  = a;   if4.b  = b;   if4.sub  = sub; if4.cin  = cin; if4.start  = 1'b1;
    if16.a = a;   if16.b = b;   if16.sub = sub; if16.cin = cin; if16.start = 1'b1;
    for (int k = 0; k <= 6; k++) begin
      @(posedge clk);
      #1;
      if (k == 0) begin
        if16.start = 1'b0;
        if (!hold) if4.start = 1'b0;
      end
      if (k == 5) if4.start = 1'b0;
      chk_cycle({tag, "/c4"}, 4, k, if4.busy, if4.done, if4.sum, if4.cout, if4.ovf, exp);
      chk_cycle({tag, "/c16"}, 1, k, if16.busy, if16.done, if16.sum, if16.cout, if16.ovf, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    check({tag, " c4 sum"},   32'(if4.sum),   32'h0);
    check({tag, " c4 flags"}, 32'({if4.cout, if4.ovf, if4.busy, if4.done}), 32'h0);
    check({tag, " c16 sum"},  32'(if16.sum),  32'h0);
    check({tag, " c16 flags"}, 32'({if16.cout, if16.ovf, if16.busy, if16.done}), 32'h0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    if4.start  = 1'b0; if4.sub  = 1'b0; if4.cin  = 1'b0; if4.a  = '0; if4.b  = '0;
    if16.start = 1'b0; if16.sub = 1'b0; if16.cin = 1'b0; if16.a = '0; if16.b = '0;

    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    run_op("add_basic",   16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b0);
    run_op("add_ripple",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    run_op("add_ovf",     16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    run_op("add_cin",     16'h1234, 16'h0FFF, 1'b0, 1'b1, 1'b0);
    run_op("sub_pos",     16'h0005, 16'h0003, 1'b1, 1'b0, 1'b0);
    run_op("sub_neg",     16'h0003, 16'h0005, 1'b1, 1'b0, 1'b0);
    run_op("sub_pos_cin", 16'h0005, 16'h0003, 1'b1, 1'b1, 1'b0);
    run_op("sub_neg_cin", 16'h0003, 16'h0005, 1'b1, 1'b1, 1'b0);
    run_op("sub_ovf",     16'h0000, 16'h8000, 1'b1, 1'b0, 1'b0);
    run_op("hold_start",  16'hA5A5, 16'h5A5B, 1'b0, 1'b0, 1'b1);

    // Abort mid-RUN: reset must clear everything without a clock edge.
    @(negedge clk);
    if4.a = 16'h1111; if4.b = 16'h2222; if4.sub = 1'b0; if4.cin = 1'b0; if4.start = 1'b1;
    @(posedge clk);
    #1;
    if4.start = 1'b0;
    @(posedge clk);
    #1;
    check("abort pre busy", 32'(if4.busy), 32'h1);
    rst_n = 1'b0;
    #1;
    chk_zero("abort");
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("abort no done k%0d", k), 32'(if4.done), 32'h0);
      check($sformatf("abort idle k%0d", k), 32'(if4.busy), 32'h0);
    end
    run_op("after_abort", 16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      run_op($sformatf("rnd%0d", n), 16'($urandom), 16'($urandom),
             1'($urandom), 1'($urandom), bit'($urandom_range(0, 3) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
